fetch_pc_btb: RTL and testbench
===============================

// Module: fetch_pc_btb
// PURPOSE
//  Fetch-side PC generator with a direct-mapped branch target buffer (BTB).
//  Sits in IF and produces the fetch PC plus a branch prediction for it.
//  Consumes the IF stall and load_pc redirect from the hazard controller.
//  Trains the BTB from decode-stage branch resolution.
// PARAMETERS
//  ADDR_WIDTH   32            PC width in bits
//  BTB_ENTRIES  16            BTB entries; power of two, >= 2
//  RESET_PC     32'h0040_0000 PC value loaded on reset
// PORTS
//  clk          in   1           clock
//  rst          in   1           reset; one clock; reset is asynchronous and active-high
//  if_stall     in   1           hold PC (the i2i stall)
//  load_we      in   1           redirect request from the hazard controller
//  load_new_pc  in   ADDR_WIDTH  redirect target
//  upd_valid    in   1           decode resolution valid this cycle
//  upd_pc       in   ADDR_WIDTH  PC of the resolved instruction
//  upd_is_branch in  1           resolved instruction is a branch or jump
//  upd_taken    in   1           resolved outcome
//  upd_target   in   ADDR_WIDTH  resolved target
//  fetch_pc     out  ADDR_WIDTH  current fetch PC (registered)
//  pred_valid   out  1           BTB hit for fetch_pc
//  pred_taken   out  1           predicted taken (counter MSB); 0 when no hit
//  pred_target  out  ADDR_WIDTH  predicted target; fetch_pc+4 when no hit or not taken
// BEHAVIOUR
//  Reset (async, rst=1):
//   - fetch_pc=RESET_PC.
//   - All BTB valid bits cleared, so pred_valid=0 and pred_taken=0.
//   - Reset mid-operation discards any pending update.
//  PC update, priority high to low, each clock edge:
//   1) load_we: fetch_pc <= load_new_pc. Load overrides if_stall.
//   2) if_stall: fetch_pc holds.
//   3) else fetch_pc <= pred_taken ? pred_target : fetch_pc+4.
//  Adder wraps modulo 2^ADDR_WIDTH. PC bits [1:0] are passed through and not checked.
//  Lookup: zero-latency combinational read indexed by fetch_pc.
//   - IDX=$clog2(BTB_ENTRIES); index=pc[IDX+1:2]; tag=pc[ADDR_WIDTH-1:IDX+2].
//   - hit = valid[index] && tag matches.
//  Entry contents: valid, tag, target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
//  Update: 1-cycle write when upd_valid=1; it is not blocked by if_stall.
//   - Hit, is_branch, taken: counter++ (saturate at 11); target <= upd_target.
//   - Hit, is_branch, not taken: counter-- (saturate at 00); target kept.
//   - Hit, !is_branch: entry invalidated (alias cleanup).
//   - Miss, is_branch, taken: allocate or overwrite the slot; counter=10; tag and target written.
//   - Miss, otherwise: no change.
//  Same-cycle lookup and update of one entry: the lookup sees the old contents.
//   The new contents are visible the next cycle.
//  Outputs have no handshake. Outputs are valid every cycle after reset deassert.
// STRUCTURE
//  Shared package (mips_core_pkg):
//   - btb_cnt_t enum {SNT,WNT,WT,ST}
//   - btb_entry_t struct {valid, tag, target, cnt}
//   - RESET_PC default constant
//  Sub-module btb_array:
//   - Entry storage, combinational lookup port, synchronous update port, async clear.
//   - Holds the counter saturation and allocate/invalidate logic.
//  The top holds the PC register, the next-PC mux and the +4 adder.
// TESTING
//  1 Assert rst mid-run, then release -> fetch_pc=0x0040_0000 immediately (async), pred_valid=0; then 0x0040_0004, 0x0040_0008 on successive edges.
//  2 if_stall=1 for 3 cycles at PC 0x0040_0008 -> PC holds. Same cycle as stall, load_we=1, load_new_pc=0x0040_0200 -> next PC 0x0040_0200.
//  3 upd taken branch pc=0x0040_0010, target=0x0040_0100. Later fetch reaches 0x0040_0010 -> pred_valid=1, pred_taken=1, next PC 0x0040_0100.
//  4 Two not-taken updates on that entry (10->01->00) -> pred_valid=1, pred_taken=0, next PC 0x0040_0014. Three taken updates -> counter saturates at 11.
//  5 Alias at 0x0040_0050 (same index, different tag), taken, target 0x0040_0300 -> replaces the entry; lookup at 0x0040_0010 misses.
//   Then upd pc=0x0040_0050 with is_branch=0 -> entry invalidated.
//  6 Update and lookup of the same entry in one cycle -> old prediction this cycle, new prediction the next cycle.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: BTB counter encoding, BTB entry layout, reset PC.
// Exports: btb_cnt_t, btb_entry_t, RESET_PC_DEF, cnt_inc/cnt_dec/cnt_taken.
package mips_core_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 32;
  localparam int unsigned BTB_ENTRIES_DEF = 16;
  localparam int unsigned BTB_IDX_DEF     = $clog2(BTB_ENTRIES_DEF);
  localparam int unsigned BTB_TAG_W_DEF   = ADDR_WIDTH_DEF - BTB_IDX_DEF - 2;
  localparam logic [ADDR_WIDTH_DEF-1:0] RESET_PC_DEF = 32'h0040_0000;

  // 2-bit saturating direction counter; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_cnt_t;

  // Entry layout for the default configuration.
  typedef struct packed {
    logic                      valid;
    logic [BTB_TAG_W_DEF-1:0]  tag;
    logic [ADDR_WIDTH_DEF-1:0] target;
    btb_cnt_t                  cnt;
  } btb_entry_t;

  function automatic btb_cnt_t cnt_inc(input btb_cnt_t c);
    return (c == ST) ? ST : btb_cnt_t'(2'(c) + 2'd1);
  endfunction

  function automatic btb_cnt_t cnt_dec(input btb_cnt_t c);
    return (c == SNT) ? SNT : btb_cnt_t'(2'(c) - 2'd1);
  endfunction

  function automatic logic cnt_taken(input btb_cnt_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/fetch_pc_btb_array.sv
// Direct-mapped BTB storage: combinational lookup port, synchronous update
// port with counter saturation and allocate/invalidate, async clear.
// Ports:
//   clk, rst                  clock, async active-high reset (clears valids)
//   i_lk_pc                   lookup PC
//   o_lk_hit/o_lk_taken       hit, and predicted taken (0 on miss)
//   o_lk_target               stored target of the indexed entry
//   i_upd_*                   decode-stage resolution (valid, pc, is_branch,
//                             taken, target)
module btb_array
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_lk_pc,
  output logic                  o_lk_hit,
  output logic                  o_lk_taken,
  output logic [ADDR_WIDTH-1:0] o_lk_target,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic                  i_upd_is_branch,
  input  logic                  i_upd_taken,
  input  logic [ADDR_WIDTH-1:0] i_upd_target
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX - 2;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  r_target [BTB_ENTRIES];
  btb_cnt_t               r_cnt    [BTB_ENTRIES];

  logic [IDX-1:0]   w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX-1:0]   w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_unused_low_bits;

  // Instruction alignment bits never take part in index or tag.
  assign w_unused_low_bits = ^{i_lk_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_idx = i_lk_pc[IDX+1:2];
  assign w_lk_tag = i_lk_pc[ADDR_WIDTH-1:IDX+2];
  assign w_up_idx = i_upd_pc[IDX+1:2];
  assign w_up_tag = i_upd_pc[ADDR_WIDTH-1:IDX+2];

  // Lookup reads pre-update contents; writes land at the clock edge.
  assign o_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_lk_taken  = o_lk_hit && cnt_taken(r_cnt[w_lk_idx]);
  assign o_lk_target = r_target[w_lk_idx];

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Training: train on hit, allocate on taken-branch miss, drop non-branch aliases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= SNT;
      end
    end else if (i_upd_valid) begin
      if (w_up_hit) begin
        if (!i_upd_is_branch) begin
          r_valid[w_up_idx] <= 1'b0;
        end else if (i_upd_taken) begin
          r_cnt[w_up_idx]    <= cnt_inc(r_cnt[w_up_idx]);
          r_target[w_up_idx] <= i_upd_target;
        end else begin
          r_cnt[w_up_idx] <= cnt_dec(r_cnt[w_up_idx]);
        end
      end else if (i_upd_is_branch && i_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd_target;
        r_cnt[w_up_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_btb.sv
// Fetch PC generator with direct-mapped BTB prediction for the current PC.
// Ports:
//   clk, rst            clock, async active-high reset (PC <= RESET_PC)
//   if_stall            hold the PC
//   load_we/load_new_pc redirect from the hazard controller (beats stall)
//   upd_*               decode-stage branch resolution used to train the BTB
//   fetch_pc            registered fetch PC
//   pred_valid          BTB hit for fetch_pc
//   pred_taken          predicted taken (0 on miss)
//   pred_target         predicted next PC (fetch_pc+4 unless hit and taken)
module fetch_pc_btb
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stall,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_new_pc,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target
);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_lk_hit;
  logic                  w_lk_taken;
  logic [ADDR_WIDTH-1:0] w_lk_target;

  btb_array #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .i_lk_pc         (r_fetch_pc),
    .o_lk_hit        (w_lk_hit),
    .o_lk_taken      (w_lk_taken),
    .o_lk_target     (w_lk_target),
    .i_upd_valid     (upd_valid),
    .i_upd_pc        (upd_pc),
    .i_upd_is_branch (upd_is_branch),
    .i_upd_taken     (upd_taken),
    .i_upd_target    (upd_target)
  );

  // Sequential fetch wraps modulo 2^ADDR_WIDTH.
  assign w_pc_plus4 = r_fetch_pc + ADDR_WIDTH'(4);

  assign pred_valid  = w_lk_hit;
  assign pred_taken  = w_lk_taken;
  assign pred_target = w_lk_taken ? w_lk_target : w_pc_plus4;

  // Next-PC priority: redirect, then stall, then prediction.
  always_comb begin
    w_next_pc = pred_target;
    if (load_we) begin
      w_next_pc = load_new_pc;
    end else if (if_stall) begin
      w_next_pc = r_fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else begin
      r_fetch_pc <= w_next_pc;
    end
  end

  assign fetch_pc = r_fetch_pc;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Directed bench for fetch_pc_btb: reset, stall/redirect, BTB allocate,
// counter training and saturation, aliasing, same-cycle update, PC wrap.
module tb_fetch_pc_btb;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        load_we;
  logic [31:0] load_new_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;

  int total;
  int bad;

  fetch_pc_btb dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .load_we       (load_we),
    .load_new_pc   (load_new_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_is_branch (upd_is_branch),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .fetch_pc      (fetch_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_taken = tk; upd_target = tgt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (fetch_pc !== 32'h0040_000C) begin bad++; $display("FAIL run_pc got=%h exp=%h", fetch_pc, 32'h0040_000C); end
    // Pending update is overtaken by an async reset before its edge.
    drive_upd(32'h0040_0008, 1'b1, 1'b1, 32'h0040_0800);
    #2 rst = 1'b1;
    #1;
    total++; if (fetch_pc !== 32'h0040_0000) begin bad++; $display("FAIL async_rst_pc got=%h exp=%h", fetch_pc, 32'h0040_0000); end
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b exp=0", pred_valid); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL async_rst_taken got=%b exp=0", pred_taken); end
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
    total++; if (fetch_pc !== 32'h0040_0000) begin bad++; $display("FAIL rst_hold_pc got=%h exp=%h", fetch_pc, 32'h0040_0000); end
    tick();
    total++; if (fetch_pc !== 32'h0040_0004) begin bad++; $display("FAIL rst_pc1 got=%h exp=%h", fetch_pc, 32'h0040_0004); end
    tick();
    total++; if (fetch_pc !== 32'h0040_0008) begin bad++; $display("FAIL rst_pc2 got=%h exp=%h", fetch_pc, 32'h0040_0008); end
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL rst_discard_upd got=%b exp=0", pred_valid); end
    total++; if (pred_target !== 32'h0040_000C) begin bad++; $display("FAIL rst_miss_tgt got=%h exp=%h", pred_target, 32'h0040_000C); end
  endtask

  task automatic test_stall_load;
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (fetch_pc !== 32'h0040_0008) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, fetch_pc, 32'h0040_0008); end
    end
    load_we = 1'b1; load_new_pc = 32'h0040_0200;
    tick();
    total++; if (fetch_pc !== 32'h0040_0200) begin bad++; $display("FAIL load_over_stall got=%h exp=%h", fetch_pc, 32'h0040_0200); end
    load_we = 1'b0; if_stall = 1'b0;
    tick();
    total++; if (fetch_pc !== 32'h0040_0204) begin bad++; $display("FAIL after_load got=%h exp=%h", fetch_pc, 32'h0040_0204); end
  endtask

  task automatic test_taken_branch;
    // Update while stalled: training is not blocked by the stall.
    if_stall = 1'b1;
    drive_upd(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    tick();
    upd_valid = 1'b0;
    total++; if (fetch_pc !== 32'h0040_0204) begin bad++; $display("FAIL stall_upd_pc got=%h exp=%h", fetch_pc, 32'h0040_0204); end
    load_we = 1'b1; load_new_pc = 32'h0040_0008;
    tick();
    load_we = 1'b0; if_stall = 1'b0;
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL br_miss8 got=%b exp=0", pred_valid); end
    tick();
    total++; if (fetch_pc !== 32'h0040_000C) begin bad++; $display("FAIL br_pc_c got=%h exp=%h", fetch_pc, 32'h0040_000C); end
    tick();
    total++; if (fetch_pc !== 32'h0040_0010) begin bad++; $display("FAIL br_pc_10 got=%h exp=%h", fetch_pc, 32'h0040_0010); end
    total++; if (pred_valid !== 1'b1) begin bad++; $display("FAIL br_hit got=%b exp=1", pred_valid); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL br_taken got=%b exp=1", pred_taken); end
    total++; if (pred_target !== 32'h0040_0100) begin bad++; $display("FAIL br_tgt got=%h exp=%h", pred_target, 32'h0040_0100); end
    tick();
    total++; if (fetch_pc !== 32'h0040_0100) begin bad++; $display("FAIL br_redirect got=%h exp=%h", fetch_pc, 32'h0040_0100); end
  endtask

  task automatic test_counter;
    logic        tk_tab   [6];
    logic [31:0] tg_tab   [6];
    logic        exp_tk   [6];
    logic [31:0] exp_tg   [6];
    // Park at 0x0040_0010 (counter WT) and train it.
    if_stall = 1'b1;
    load_we = 1'b1; load_new_pc = 32'h0040_0010;
    tick();
    load_we = 1'b0;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL cnt_start got=%b exp=1", pred_taken); end
    for (int i = 0; i < 2; i++) begin
      drive_upd(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0999);
      tick();
      upd_valid = 1'b0;
      total++; if (pred_valid !== 1'b1) begin bad++; $display("FAIL cnt_nt_valid%0d got=%b exp=1", i, pred_valid); end
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cnt_nt_taken%0d got=%b exp=0", i, pred_taken); end
      total++; if (pred_target !== 32'h0040_0014) begin bad++; $display("FAIL cnt_nt_tgt%0d got=%h exp=%h", i, pred_target, 32'h0040_0014); end
    end
    if_stall = 1'b0;
    tick();
    total++; if (fetch_pc !== 32'h0040_0014) begin bad++; $display("FAIL cnt_nt_fall got=%h exp=%h", fetch_pc, 32'h0040_0014); end
    if_stall = 1'b1;
    load_we = 1'b1; load_new_pc = 32'h0040_0010;
    tick();
    load_we = 1'b0;
    // From SNT: T,T,T,T(new target),NT,NT -> WNT,WT,ST,ST,WT,WNT
    tk_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tg_tab = '{32'h0040_0100, 32'h0040_0100, 32'h0040_0100, 32'h0040_0180, 32'h0040_0999, 32'h0040_0999};
    exp_tk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_tg = '{32'h0040_0014, 32'h0040_0100, 32'h0040_0100, 32'h0040_0180, 32'h0040_0180, 32'h0040_0014};
    for (int i = 0; i < 6; i++) begin
      drive_upd(32'h0040_0010, 1'b1, tk_tab[i], tg_tab[i]);
      tick();
      upd_valid = 1'b0;
      total++; if (pred_taken !== exp_tk[i]) begin bad++; $display("FAIL cnt_seq_taken%0d got=%b exp=%b", i, pred_taken, exp_tk[i]); end
      total++; if (pred_target !== exp_tg[i]) begin bad++; $display("FAIL cnt_seq_tgt%0d got=%h exp=%h", i, pred_target, exp_tg[i]); end
    end
  endtask

  task automatic test_alias;
    // Still stalled at 0x0040_0010; 0x0040_0050 shares index 4.
    drive_upd(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
    tick();
    upd_valid = 1'b0;
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL alias_evict got=%b exp=0", pred_valid); end
    total++; if (pred_target !== 32'h0040_0014) begin bad++; $display("FAIL alias_evict_tgt got=%h exp=%h", pred_target, 32'h0040_0014); end
    load_we = 1'b1; load_new_pc = 32'h0040_0050;
    tick();
    load_we = 1'b0;
    total++; if (pred_valid !== 1'b1) begin bad++; $display("FAIL alias_hit got=%b exp=1", pred_valid); end
    total++; if (pred_target !== 32'h0040_0300) begin bad++; $display("FAIL alias_tgt got=%h exp=%h", pred_target, 32'h0040_0300); end
    // Not-taken miss on the same index must leave the entry alone.
    drive_upd(32'h0040_0090, 1'b1, 1'b0, 32'h0040_0999);
    tick();
    upd_valid = 1'b0;
    total++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin bad++; $display("FAIL alias_nt_miss got=%b%b exp=11", pred_valid, pred_taken); end
    drive_upd(32'h0040_0050, 1'b0, 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL alias_inval got=%b exp=0", pred_valid); end
    total++; if (pred_target !== 32'h0040_0054) begin bad++; $display("FAIL alias_inval_tgt got=%h exp=%h", pred_target, 32'h0040_0054); end
  endtask

  task automatic test_same_cycle;
    // Stalled at 0x0040_0050 with the entry invalid.
    drive_upd(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0400);
    #1;
    total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL same_old_valid got=%b exp=0", pred_valid); end
    tick();
    upd_valid = 1'b0;
    total++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin bad++; $display("FAIL same_new got=%b%b exp=11", pred_valid, pred_taken); end
    total++; if (pred_target !== 32'h0040_0400) begin bad++; $display("FAIL same_new_tgt got=%h exp=%h", pred_target, 32'h0040_0400); end
    drive_upd(32'h0040_0050, 1'b1, 1'b0, 32'h0040_0999);
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_old_taken got=%b exp=1", pred_taken); end
    tick();
    upd_valid = 1'b0;
    total++; if (pred_taken !== 1'b0 || pred_valid !== 1'b1) begin bad++; $display("FAIL same_new_nt got=%b%b exp=10", pred_valid, pred_taken); end
    if_stall = 1'b0;
    tick();
    total++; if (fetch_pc !== 32'h0040_0054) begin bad++; $display("FAIL same_fall got=%h exp=%h", fetch_pc, 32'h0040_0054); end
  endtask

  task automatic test_wrap;
    load_we = 1'b1; load_new_pc = 32'hFFFF_FFF8;
    tick();
    load_we = 1'b0;
    total++; if (fetch_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_load got=%h exp=%h", fetch_pc, 32'hFFFF_FFF8); end
    tick();
    total++; if (pred_target !== 32'h0000_0000) begin bad++; $display("FAIL wrap_tgt got=%h exp=%h", pred_target, 32'h0); end
    tick();
    total++; if (fetch_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", fetch_pc, 32'h0); end
    // Low bits pass through; 0x0040_0052 hits entry 0x0040_0050 (WNT).
    load_we = 1'b1; load_new_pc = 32'h0040_0052;
    tick();
    load_we = 1'b0;
    total++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin bad++; $display("FAIL low_bits_hit got=%b%b exp=10", pred_valid, pred_taken); end
    tick();
    total++; if (fetch_pc !== 32'h0040_0056) begin bad++; $display("FAIL low_bits_pc got=%h exp=%h", fetch_pc, 32'h0040_0056); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; if_stall = 1'b0; load_we = 1'b0; load_new_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = '0;
    test_reset();
    test_stall_load();
    test_taken_branch();
    test_counter();
    test_alias();
    test_same_cycle();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
